// File: rtl/kd_tree_pkg.sv
// Shared constants and state encoding for the KD-tree internal-node loader.
// The tree has 63 internal nodes; each 22-bit record is sent as two 11-bit halves.
package kd_tree_pkg;

   localparam int HALF_WIDTH     = 11;
   localparam int INTERNAL_WIDTH = 2 * HALF_WIDTH;
   localparam int NUM_NODES      = 63;
   localparam int COUNT_WIDTH    = 6;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOW  = 3'd1,
      ST_HIGH = 3'd2,
      ST_EMIT = 3'd3,
      ST_DONE = 3'd4
   } sender_state_t;

   // The record currently emitted is the final one of the load.
   function automatic logic is_last_node(input logic [COUNT_WIDTH-1:0] count);
      return count == COUNT_WIDTH'(NUM_NODES - 1);
   endfunction

endpackage

// File: rtl/kd_internal_node_sender_if.sv
// Host-side half-word stream and tree-side record port of the internal-node sender.
// The sender implements the slave view; the host/tree environment implements the master view.
interface kd_internal_node_sender_if;
   import kd_tree_pkg::*;

   logic                      start;
   logic                      abort;
   logic                      stall;
   logic                      in_valid;
   logic [HALF_WIDTH-1:0]     in_data;
   logic                      in_ready;
   logic                      sender_enable;
   logic [INTERNAL_WIDTH-1:0] sender_data;
   logic [COUNT_WIDTH-1:0]    node_count;
   logic                      busy;
   logic                      done;

   modport master (
      output start, abort, stall, in_valid, in_data,
      input  in_ready, sender_enable, sender_data, node_count, busy, done
   );

   modport slave (
      input  start, abort, stall, in_valid, in_data,
      output in_ready, sender_enable, sender_data, node_count, busy, done
   );

endinterface

// File: rtl/kd_internal_node_sender.sv
// Packs low/high half-word pairs into 22-bit node records and strobes each record to the tree,
// counting records and flagging completion after the last internal node.
module kd_internal_node_sender
   import kd_tree_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst_n,
   kd_internal_node_sender_if.slave    bus
);

   sender_state_t             state_q, state_d;
   logic [INTERNAL_WIDTH-1:0] data_q, data_d;
   logic [COUNT_WIDTH-1:0]    count_q, count_d;

   // Next-state, staging and counter update; abort outranks stall, stall freezes everything.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      count_d = count_q;
      if (bus.abort) begin
         state_d = ST_IDLE;
         count_d = '0;
      end else if (bus.stall) begin
         state_d = state_q;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  state_d = ST_LOW;
                  count_d = '0;
               end else begin
                  state_d = state_q;
               end
            end
            ST_LOW: begin
               if (bus.in_valid) begin
                  data_d[HALF_WIDTH-1:0] = bus.in_data;
                  state_d                = ST_HIGH;
               end else begin
                  state_d = ST_LOW;
               end
            end
            ST_HIGH: begin
               if (bus.in_valid) begin
                  data_d[INTERNAL_WIDTH-1:HALF_WIDTH] = bus.in_data;
                  state_d                             = ST_EMIT;
               end else begin
                  state_d = ST_HIGH;
               end
            end
            ST_EMIT: begin
               count_d = count_q + COUNT_WIDTH'(1);
               state_d = is_last_node(count_q) ? ST_DONE : ST_LOW;
            end
            default: begin
               state_d = ST_IDLE;
               count_d = '0;
            end
         endcase
      end
   end

   // State, staging record and node counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         count_q <= count_d;
      end
   end

   // Strobes decode from state only; an abort in EMIT drops the pending record.
   assign bus.in_ready      = ((state_q == ST_LOW) || (state_q == ST_HIGH)) && !bus.stall && !bus.abort;
   assign bus.sender_enable = (state_q == ST_EMIT) && !bus.stall && !bus.abort;
   assign bus.sender_data   = data_q;
   assign bus.node_count    = count_q;
   assign bus.busy          = (state_q == ST_LOW) || (state_q == ST_HIGH) || (state_q == ST_EMIT);
   assign bus.done          = (state_q == ST_DONE);

endmodule
